// File: rtl/vending_machine_gen.sv
// Vending controller: coin intake, per-item stock, refill, greedy change
// dispensing (one coin per cycle) with full-refund rollback.
module vending_machine_gen #(
    parameter int CNT_W      = 3,
    parameter int IN_W       = 2,
    parameter int INIT_CNT   = 2,
    parameter int STOCK_W    = 2,
    parameter int INIT_STOCK = 3,
    parameter int VAL_W      = 10,
    parameter int COST_A     = 8,
    parameter int COST_B     = 15,
    parameter int COST_C     = 22
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*IN_W-1:0]   coinIn,
    input  logic [1:0]          itemTypeIn,
    input  logic                refillEn,
    output logic [4*CNT_W-1:0]  coinOut,
    output logic [1:0]          itemTypeOut,
    output logic [1:0]          serviceTypeOut,
    output logic [2:0]          soldOut,
    output logic                refund,
    output logic                p_change,
    output logic                p_balance
);
    localparam int CNT_MAX   = 2**CNT_W - 1;
    localparam int STOCK_MAX = 2**STOCK_W - 1;

    typedef enum logic [1:0] {
        S_OFF    = 2'b00,
        S_ON     = 2'b01,
        S_BUSY   = 2'b10,
        S_REFUND = 2'b11
    } state_t;

    // Coin index k: 3 = 50, 2 = 10, 1 = 5, 0 = 1 (matches the packed port layout).
    function automatic logic [VAL_W-1:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd3:    return VAL_W'(50);
            2'd2:    return VAL_W'(10);
            2'd1:    return VAL_W'(5);
            default: return VAL_W'(1);
        endcase
    endfunction

    function automatic logic [VAL_W-1:0] item_cost(input logic [1:0] item);
        case (item)
            2'd1:    return VAL_W'(COST_A);
            2'd2:    return VAL_W'(COST_B);
            2'd3:    return VAL_W'(COST_C);
            default: return '0;
        endcase
    endfunction

    state_t                       state_q, state_d;
    logic [3:0][CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0][STOCK_W-1:0]      stock_q, stock_d;
    logic [3:0][CNT_W-1:0]        coin_out_q, coin_out_d;
    logic [3:0][IN_W-1:0]         latched_q, latched_d;
    logic [1:0]                   item_out_q, item_out_d;
    logic [1:0]                   item_q, item_d;
    logic [1:0]                   coin_type_q, coin_type_d;
    logic                         refund_q, refund_d;
    logic [VAL_W-1:0]             in_value_q, in_value_d;
    logic [VAL_W-1:0]             svc_value_q, svc_value_d;
    logic [VAL_W-1:0]             init_value_q, init_value_d;

    logic [3:0][IN_W-1:0]         coin_f;
    logic [3:0][CNT_W:0]          cnt_sum;
    logic [VAL_W-1:0]             machine_value, coin_in_value, coin_out_value, coin_v;
    logic                         overflow;
    logic [2:0]                   req_onehot;
    logic                         req_sold_out;

    assign coin_f = coinIn;

    always_comb begin
        machine_value  = '0;
        coin_in_value  = '0;
        coin_out_value = '0;
        overflow       = 1'b0;
        cnt_sum        = '0;
        for (int k = 0; k < 4; k++) begin
            machine_value  = machine_value + VAL_W'(cnt_q[k]) * coin_value(2'(k));
            coin_in_value  = coin_in_value + VAL_W'(coin_f[k]) * coin_value(2'(k));
            coin_out_value = coin_out_value + VAL_W'(coin_out_q[k]) * coin_value(2'(k));
            cnt_sum[k]     = (CNT_W+1)'(cnt_q[k]) + (CNT_W+1)'(coin_f[k]);
            if (cnt_sum[k] > (CNT_W+1)'(CNT_MAX)) overflow = 1'b1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_sold
        assign soldOut[i] = (stock_q[i] == '0);
    end

    assign req_onehot   = {itemTypeIn == 2'd3, itemTypeIn == 2'd2, itemTypeIn == 2'd1};
    assign req_sold_out = |(soldOut & req_onehot);
    assign coin_v       = coin_value(coin_type_q);

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        stock_d      = stock_q;
        coin_out_d   = coin_out_q;
        latched_d    = latched_q;
        item_out_d   = item_out_q;
        item_d       = item_q;
        coin_type_d  = coin_type_q;
        refund_d     = refund_q;
        in_value_d   = in_value_q;
        svc_value_d  = svc_value_q;
        init_value_d = init_value_q;

        case (state_q)
            S_ON: begin
                if (refillEn) begin
                    for (int k = 0; k < 4; k++) begin
                        if (cnt_sum[k] > (CNT_W+1)'(CNT_MAX)) cnt_d[k] = CNT_W'(CNT_MAX);
                        else                                  cnt_d[k] = CNT_W'(cnt_sum[k]);
                    end
                    stock_d = {3{STOCK_W'(STOCK_MAX)}};
                end else if (itemTypeIn != 2'd0) begin
                    latched_d    = coin_f;
                    in_value_d   = coin_in_value;
                    init_value_d = machine_value;
                    item_d       = itemTypeIn;
                    if (req_sold_out || coin_in_value < item_cost(itemTypeIn) || overflow) begin
                        for (int k = 0; k < 4; k++) coin_out_d[k] = CNT_W'(coin_f[k]);
                        item_out_d = 2'd0;
                        refund_d   = 1'b1;
                        state_d    = S_OFF;
                    end else begin
                        for (int k = 0; k < 4; k++) cnt_d[k] = CNT_W'(cnt_sum[k]);
                        svc_value_d = coin_in_value - item_cost(itemTypeIn);
                        coin_out_d  = '0;
                        coin_type_d = 2'd3;
                        state_d     = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (svc_value_q >= coin_v && cnt_q[coin_type_q] != '0) begin
                    coin_out_d[coin_type_q] = coin_out_q[coin_type_q] + CNT_W'(1);
                    cnt_d[coin_type_q]      = cnt_q[coin_type_q] - CNT_W'(1);
                    svc_value_d             = svc_value_q - coin_v;
                end else if (coin_type_q != 2'd0) begin
                    coin_type_d = coin_type_q - 2'd1;
                end else if (svc_value_q == '0) begin
                    item_out_d = item_q;
                    refund_d   = 1'b0;
                    state_d    = S_OFF;
                    case (item_q)
                        2'd1:    stock_d[0] = stock_q[0] - STOCK_W'(1);
                        2'd2:    stock_d[1] = stock_q[1] - STOCK_W'(1);
                        2'd3:    stock_d[2] = stock_q[2] - STOCK_W'(1);
                        default: ;
                    endcase
                end else begin
                    state_d = S_REFUND;
                end
            end
            S_REFUND: begin
                // Undo the partial change and the accepted coins; the sum is never negative.
                for (int k = 0; k < 4; k++) begin
                    cnt_d[k]      = CNT_W'((CNT_W+1)'(cnt_q[k]) + (CNT_W+1)'(coin_out_q[k])
                                           - (CNT_W+1)'(latched_q[k]));
                    coin_out_d[k] = CNT_W'(latched_q[k]);
                end
                item_out_d = 2'd0;
                refund_d   = 1'b1;
                state_d    = S_OFF;
            end
            default: begin
                coin_out_d = '0;
                item_out_d = 2'd0;
                refund_d   = 1'b0;
                state_d    = S_ON;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_ON;
            cnt_q        <= {4{CNT_W'(INIT_CNT)}};
            stock_q      <= {3{STOCK_W'(INIT_STOCK)}};
            coin_out_q   <= '0;
            latched_q    <= '0;
            item_out_q   <= 2'd0;
            item_q       <= 2'd0;
            coin_type_q  <= 2'd3;
            refund_q     <= 1'b0;
            in_value_q   <= '0;
            svc_value_q  <= '0;
            init_value_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stock_q      <= stock_d;
            coin_out_q   <= coin_out_d;
            latched_q    <= latched_d;
            item_out_q   <= item_out_d;
            item_q       <= item_d;
            coin_type_q  <= coin_type_d;
            refund_q     <= refund_d;
            in_value_q   <= in_value_d;
            svc_value_q  <= svc_value_d;
            init_value_q <= init_value_d;
        end
    end

    assign coinOut        = coin_out_q;
    assign itemTypeOut    = item_out_q;
    assign serviceTypeOut = state_q;
    assign refund         = refund_q;
    assign p_change  = (state_q == S_OFF) && (coin_out_value + item_cost(item_out_q) != in_value_q);
    assign p_balance = (state_q == S_OFF) && (machine_value + coin_out_value != init_value_q + in_value_q);
endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed table plus hand sequences for latency, reset abort and a random
// invariant run of the vending controller.
module tb_vending_machine_gen;
    localparam logic [1:0] ST_OFF = 2'b00, ST_ON = 2'b01, ST_BUSY = 2'b10, ST_REF = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  coin_in;
    logic [1:0]  item_in;
    logic        refill;
    logic [11:0] coin_out;
    logic [1:0]  item_out, svc;
    logic [2:0]  sold;
    logic        refund_o, p_change, p_balance;

    int n_vec = 0;
    int n_bad = 0;

    vending_machine_gen dut (
        .clk(clk), .reset(reset), .coinIn(coin_in), .itemTypeIn(item_in), .refillEn(refill),
        .coinOut(coin_out), .itemTypeOut(item_out), .serviceTypeOut(svc), .soldOut(sold),
        .refund(refund_o), .p_change(p_change), .p_balance(p_balance)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  coin;
        logic [1:0]  item;
        logic        refill;
        int          edges;
        logic [1:0]  st;
        logic [11:0] cout;
        logic [1:0]  iout;
        logic        rf;
        logic [2:0]  so;
        logic [11:0] cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] cnts(input int n50, input int n10, input int n5, input int n1);
        logic [2:0] a, b, c, d;
        a = 3'(n50); b = 3'(n10); c = 3'(n5); d = 3'(n1);
        return {a, b, c, d};
    endfunction

    task automatic check_outs(input string tag, input logic [1:0] st, input logic [11:0] cout,
                              input logic [1:0] iout, input logic rf, input logic [2:0] so,
                              input logic [11:0] cnt);
        check({tag, " state"},    32'(svc),         32'(st));
        check({tag, " coinOut"},  32'(coin_out),    32'(cout));
        check({tag, " itemOut"},  32'(item_out),    32'(iout));
        check({tag, " refund"},   32'(refund_o),    32'(rf));
        check({tag, " soldOut"},  32'(sold),        32'(so));
        check({tag, " counts"},   32'(dut.cnt_q),   32'(cnt));
        check({tag, " p_change"}, 32'(p_change),    32'd0);
        check({tag, " p_balance"},32'(p_balance),   32'd0);
    endtask

    initial begin
        vec_t tbl[18];
        tbl[0]  = '{8'h00, 2'd0, 1'b0, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b000, cnts(2,3,2,0)};
        tbl[1]  = '{8'h10, 2'd1, 1'b0, 5, ST_REF, 12'h000, 2'd0, 1'b0, 3'b000, cnts(2,4,2,0)};
        tbl[2]  = '{8'h00, 2'd0, 1'b0, 1, ST_OFF, 12'h040, 2'd0, 1'b1, 3'b000, cnts(2,3,2,0)};
        tbl[3]  = '{8'h00, 2'd0, 1'b0, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b000, cnts(2,3,2,0)};
        tbl[4]  = '{8'h04, 2'd2, 1'b0, 1, ST_OFF, 12'h008, 2'd0, 1'b1, 3'b000, cnts(2,3,2,0)};
        tbl[5]  = '{8'h00, 2'd0, 1'b0, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b000, cnts(2,3,2,0)};
        tbl[6]  = '{8'h07, 2'd1, 1'b0, 5, ST_OFF, 12'h000, 2'd1, 1'b0, 3'b000, cnts(2,3,3,3)};
        tbl[7]  = '{8'h00, 2'd0, 1'b0, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b000, cnts(2,3,3,3)};
        tbl[8]  = '{8'h07, 2'd1, 1'b0, 5, ST_OFF, 12'h000, 2'd1, 1'b0, 3'b001, cnts(2,3,4,6)};
        tbl[9]  = '{8'h00, 2'd0, 1'b0, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b001, cnts(2,3,4,6)};
        tbl[10] = '{8'h10, 2'd1, 1'b0, 1, ST_OFF, 12'h040, 2'd0, 1'b1, 3'b001, cnts(2,3,4,6)};
        tbl[11] = '{8'h00, 2'd0, 1'b0, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b001, cnts(2,3,4,6)};
        tbl[12] = '{8'hC0, 2'd3, 1'b1, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b000, cnts(5,3,4,6)};
        tbl[13] = '{8'hC0, 2'd3, 1'b1, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b000, cnts(7,3,4,6)};
        tbl[14] = '{8'h40, 2'd3, 1'b0, 1, ST_OFF, 12'h200, 2'd0, 1'b1, 3'b000, cnts(7,3,4,6)};
        tbl[15] = '{8'h00, 2'd0, 1'b0, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b000, cnts(7,3,4,6)};
        tbl[16] = '{8'h20, 2'd2, 1'b0, 6, ST_OFF, 12'h008, 2'd2, 1'b0, 3'b000, cnts(7,5,3,6)};
        tbl[17] = '{8'h00, 2'd0, 1'b0, 1, ST_ON,  12'h000, 2'd0, 1'b0, 3'b000, cnts(7,5,3,6)};

        reset   = 1'b1;
        coin_in = 8'h00;
        item_in = 2'd0;
        refill  = 1'b0;
        #12;
        check_outs("reset", ST_ON, 12'h000, 2'd0, 1'b0, 3'b000, cnts(2,2,2,2));
        reset = 1'b0;
        tick();

        // One 10-coin for item A: accept, then 50/10/5 skipped, two 1-coins, then OFF.
        coin_in = 8'h10;
        item_in = 2'd1;
        tick();
        coin_in = 8'h00;
        item_in = 2'd0;
        check("t1 accept state", 32'(svc), 32'(ST_BUSY));
        check("t1 accept counts", 32'(dut.cnt_q), 32'(cnts(2,3,2,2)));
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("t1 busy step %0d", i), 32'(svc), 32'(ST_BUSY));
        end
        tick();
        check_outs("t1 done", ST_OFF, 12'h002, 2'd1, 1'b0, 3'b000, cnts(2,3,2,0));
        check("t1 stockA", 32'(dut.stock_q[0]), 32'd2);

        for (int v = 0; v < 18; v++) begin
            coin_in = tbl[v].coin;
            item_in = tbl[v].item;
            refill  = tbl[v].refill;
            tick();
            coin_in = 8'h00;
            item_in = 2'd0;
            refill  = 1'b0;
            for (int e = 1; e < tbl[v].edges; e++) tick();
            check_outs($sformatf("v%0d", v), tbl[v].st, tbl[v].cout, tbl[v].iout,
                       tbl[v].rf, tbl[v].so, tbl[v].cnt);
        end

        // Reset asserted mid-transaction aborts it immediately.
        coin_in = 8'h20;
        item_in = 2'd2;
        tick();
        coin_in = 8'h00;
        item_in = 2'd0;
        check("t6 busy", 32'(svc), 32'(ST_BUSY));
        #2 reset = 1'b1;
        #1;
        check("t6 state", 32'(svc), 32'(ST_ON));
        check("t6 coinOut", 32'(coin_out), 32'd0);
        check("t6 counts", 32'(dut.cnt_q), 32'(cnts(2,2,2,2)));
        check("t6 soldOut", 32'(sold), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        for (int c = 0; c < 10000; c++) begin
            coin_in = 8'($urandom);
            item_in = 2'($urandom_range(0, 3));
            refill  = ($urandom_range(0, 15) == 0);
            tick();
            check("rand p_change", 32'(p_change), 32'd0);
            check("rand p_balance", 32'(p_balance), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
